// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8-channel mux scanner.
package mux_scan_pkg;

    localparam int unsigned CH_COUNT = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Dwell counter width: clog2(dwell), never less than one bit.
    function automatic int unsigned dc_width(input int unsigned dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_8.sv
// Steps an external 8:1 mux through all channels, samples its output into a
// shadow register, and publishes each completed scan on data with a valid strobe.
module mux_scan_8
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic                m,
    output logic                s0,
    output logic                s1,
    output logic                s2,
    output logic [CH_COUNT-1:0] data,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned DC_W = dc_width(DWELL);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DC_W-1:0]     dc_q, dc_d;
    logic [CH_COUNT-1:0] shadow_q, shadow_d;
    logic [CH_COUNT-1:0] data_q, data_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    // Next-state, counters, capture and registered-output values.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dc_d     = dc_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            SCAN: begin
                if (dc_q == DC_W'(DWELL - 1)) begin
                    dc_d            = '0;
                    shadow_d[idx_q] = m;
                    if (idx_q == IDX_W'(CH_COUNT - 1)) begin
                        state_d = DONE;
                        // Last channel goes straight to data; shadow bit 7 is not yet valid.
                        data_d  = {m, shadow_q[CH_COUNT-2:0]};
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    dc_d = dc_q + DC_W'(1);
                end
            end
            DONE: begin
                if (start || cont) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    dc_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                // IDLE and the unused encoding behave identically.
                if (start || cont) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    dc_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        sel_d   = (state_d == SCAN) ? idx_d : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dc_q     <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dc_q     <= dc_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign s0    = sel_q[2];
    assign s1    = sel_q[1];
    assign s2    = sel_q[0];
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
